// File: rtl/mdu_hilo.sv
`default_nettype none
//============================================================================
// Module   : mdu_hilo
// Purpose  : Iterative multiply/divide unit with HI/LO result registers.
//            MULT/MULTU use shift-add, DIV/DIVU use restoring division.
//            Each takes WIDTH steps; MTHI/MTLO complete at the accept edge.
// Revision : 1.0 - initial release
//============================================================================
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [2:0] c_op_mult  = 3'b001;
    localparam logic [2:0] c_op_multu = 3'b010;
    localparam logic [2:0] c_op_div   = 3'b011;
    localparam logic [2:0] c_op_divu  = 3'b100;
    localparam logic [2:0] c_op_mthi  = 3'b101;
    localparam logic [2:0] c_op_mtlo  = 3'b110;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_fin  = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    // Upper half: partial product / partial remainder.
    // Lower half: multiplier shifting out / dividend shifting out, quotient in.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_q;    // negate product (mult) or quotient (div)
    logic               r_neg_r;    // negate remainder (dividend was negative)
    logic               r_div0;

    logic               w_signed_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mstep;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_dstep;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo;

    // Operand conditioning at accept and the per-step datapath
    always_comb begin
        w_signed_op = (MDUOp == c_op_mult) || (MDUOp == c_op_div);
        w_a_neg     = w_signed_op & A[WIDTH-1];
        w_b_neg     = w_signed_op & B[WIDTH-1];
        w_a_mag     = w_a_neg ? (~A + 1'b1) : A;
        w_b_mag     = w_b_neg ? (~B + 1'b1) : B;

        w_hi        = r_acc[2*WIDTH-1:WIDTH];
        w_lo        = r_acc[WIDTH-1:0];

        // Shift-add: conditionally add multiplicand, keep the carry, shift right
        w_madd      = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_mstep     = {w_madd, w_lo[WIDTH-1:1]};

        // Restoring divide: extra top bit keeps the borrow unambiguous
        w_shift     = {w_hi, w_lo[WIDTH-1]};
        w_diff      = {1'b0, w_shift} - {2'b00, r_opnd};
        w_dstep     = w_diff[WIDTH+1] ? {w_shift[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],  w_lo[WIDTH-2:0], 1'b1};

        // Sign correction; divide-by-zero leaves |A| in the remainder, so
        // restoring the dividend sign yields the original A in HI
        w_prod      = r_neg_q ? (~r_acc + 1'b1) : r_acc;
        w_rem       = r_neg_r ? (~w_hi + 1'b1) : w_hi;
        w_quo       = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? (~w_lo + 1'b1) : w_lo);
    end

    // Control FSM, iteration register and HI/LO result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    done <= 1'b0;
                    if (start) begin
                        case (MDUOp)
                            c_op_mult, c_op_multu, c_op_div, c_op_divu: begin
                                r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                                r_opnd   <= w_b_mag;
                                r_is_div <= (MDUOp == c_op_div) || (MDUOp == c_op_divu);
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_div0   <= (B == '0);
                                r_cnt    <= '0;
                                busy     <= 1'b1;
                                r_state  <= c_st_run;
                            end
                            c_op_mthi: HI <= A;
                            c_op_mtlo: LO <= A;
                            default: ;
                        endcase
                    end
                end
                c_st_run: begin
                    r_acc <= r_is_div ? w_dstep : w_mstep;
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        busy    <= 1'b0;
                        r_state <= c_st_fin;
                    end
                end
                c_st_fin: begin
                    if (r_is_div) begin
                        HI <= w_rem;
                        LO <= w_quo;
                    end else begin
                        HI <= w_prod[2*WIDTH-1:WIDTH];
                        LO <= w_prod[WIDTH-1:0];
                    end
                    done    <= 1'b1;
                    r_state <= c_st_idle;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
//============================================================================
// Module   : tb_mdu_hilo
// Purpose  : Self-checking bench for mdu_hilo: directed corner cases plus
//            randomized ops against an arithmetic reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_mdu_hilo;

    localparam int W = 32;

    localparam logic [2:0] c_nop   = 3'b000;
    localparam logic [2:0] c_mult  = 3'b001;
    localparam logic [2:0] c_multu = 3'b010;
    localparam logic [2:0] c_div   = 3'b011;
    localparam logic [2:0] c_divu  = 3'b100;
    localparam logic [2:0] c_mthi  = 3'b101;
    localparam logic [2:0] c_mtlo  = 3'b110;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   MDUOp;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_hi   = '0;
    logic [W-1:0] exp_lo   = '0;

    mdu_hilo #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint p;
        int     q;
        int     r;
        logic [63:0] res;
        res = 64'h0;
        case (op)
            c_mult: begin
                p   = longint'($signed(a)) * longint'($signed(b));
                res = p;
            end
            c_multu: res = {32'h0, a} * {32'h0, b};
            c_div: begin
                if (b == 0)
                    res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {32'h0, 32'h8000_0000};
                else begin
                    q   = $signed(a) / $signed(b);
                    r   = $signed(a) % $signed(b);
                    res = {r, q};
                end
            end
            c_divu: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            default: res = 64'h0;
        endcase
        return res;
    endfunction

    // Issue one op from a post-edge point; optionally pulse a second start
    // 'inject' edges after acceptance, which must be ignored.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inject);
        int          e;
        int          busy_cnt;
        logic [63:0] res;
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom; MDUOp = 3'($urandom);
        if (op >= c_mult && op <= c_divu) begin
            e = 0;
            busy_cnt = 0;
            while (done !== 1'b1 && e < 100) begin
                if (busy === 1'b1) busy_cnt++;
                check("hold_hi", HI, exp_hi);
                check("hold_lo", LO, exp_lo);
                if (inject >= 0 && e == inject) begin
                    start = 1'b1; MDUOp = c_mult; A = $urandom; B = $urandom;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                e++;
            end
            start = 1'b0;
            res = ref_result(op, a, b);
            check("done_seen", {63'h0, done}, 64'h1);
            check("latency", e, W + 1);
            check("busy_cycles", busy_cnt, W);
            check("res_hi", HI, res[63:32]);
            check("res_lo", LO, res[31:0]);
            exp_hi = res[63:32];
            exp_lo = res[31:0];
        end else begin
            if (op == c_mthi) exp_hi = a;
            if (op == c_mtlo) exp_lo = a;
            check("mt_busy", {63'h0, busy}, 64'h0);
            check("mt_done", {63'h0, done}, 64'h0);
            check("mt_hi", HI, exp_hi);
            check("mt_lo", LO, exp_lo);
        end
        @(posedge clk); #1;
        check("after_done", {63'h0, done}, 64'h0);
        check("after_busy", {63'h0, busy}, 64'h0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(1, 20));
            4:       v = -32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; MDUOp = c_nop; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_hi", HI, 64'h0);
        check("rst_lo", LO, 64'h0);
        rst = 1'b0;

        // Directed corners
        do_op(c_multu, 32'hFFFF_FFFF, 32'd2, -1);
        do_op(c_mult,  -32'd3, 32'd5, -1);
        do_op(c_mult,  32'h8000_0000, 32'h8000_0000, -1);
        do_op(c_div,   -32'd7, 32'd2, -1);
        do_op(c_divu,  32'd7, 32'd2, -1);
        do_op(c_divu,  32'd5, 32'd0, -1);
        do_op(c_div,   -32'd9, 32'd0, -1);
        do_op(c_div,   32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op(c_div,   32'd7, -32'd2, -1);
        do_op(c_divu,  32'd100, 32'd7, 10);
        do_op(c_mthi,  32'h1234, 32'h0, -1);
        do_op(c_mtlo,  32'h5678, 32'h0, -1);
        do_op(c_nop,   32'hDEAD, 32'hBEEF, -1);
        do_op(3'b111,  32'hDEAD, 32'hBEEF, -1);

        // Reset in the middle of a multiply aborts it and clears HI/LO
        start = 1'b1; MDUOp = c_mult; A = 32'd1234; B = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("mid_busy", {63'h0, busy}, 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_done", {63'h0, done}, 64'h0);
        check("abort_hi", HI, 64'h0);
        check("abort_lo", LO, 64'h0);
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", {62'h0, busy, done}, 64'h0);
        end
        do_op(c_mult, -32'd100, 32'd77, -1);

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
